// File: rtl/pc_next_unit.sv
// Purpose : PC stage. Holds the architectural PC, fetches from instruction memory
//           over a req/ack handshake, and advances the PC from the branch selects
//           when execute commits.
// Latency : fetch takes at least 1 cycle after imem_req (wait states unbounded);
//           the PC updates on the commit edge.
// Backpressure: imem_req is held until imem_ack; the instruction is held in EXEC
//           until commit. An ack outside FETCH or a commit outside EXEC is ignored.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pc_a_src, pc_b_src    addend selects: A = 4 / imm, B = pc / rs1 (jalr)
//   imm, rs1              immediate and rs1 value of the current instruction
//   commit                execute resolved the current instruction
//   imem_req/addr/ack/rdata  instruction-memory fetch handshake
//   pc, instr, instr_valid   current PC and the latched instruction
//   retired               count of committed instructions (wraps)
//   misalign              misaligned-target trap flag
//
// Optional feature: define PC_MISALIGN_TRAP_EN to trap on a misaligned target.
// A trap parks the unit in TRAP until reset. Without the macro, bits [1:0] of
// the target are cleared and misalign stays 0.
module pc_next_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_a_src,
    input  logic            pc_b_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            commit,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [31:0]     retired,
    output logic            misalign
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            instr_valid_q;
    logic            imem_req_q;
    logic [31:0]     retired_q;
    logic            misalign_q;

    logic [XLEN-1:0] addend_a;
    logic [XLEN-1:0] addend_b;
    logic [XLEN-1:0] next_pc_d;
    logic            trap_hit;

    // Next-PC adder. The sum wraps modulo 2^XLEN. A jalr target (B = rs1)
    // always has bit 0 cleared before the alignment check or the forcing.
    always_comb begin
        addend_a  = pc_a_src ? imm : XLEN'(4);
        addend_b  = pc_b_src ? rs1 : pc_q;
        next_pc_d = addend_a + addend_b;
        if (pc_b_src) begin
            next_pc_d[0] = 1'b0;
        end
`ifdef PC_MISALIGN_TRAP_EN
        trap_hit = (next_pc_d[1:0] != 2'b00);
`else
        trap_hit     = 1'b0;
        next_pc_d[1:0] = 2'b00;
`endif
    end

    // One FSM. Every output is registered, so the asynchronous reset drops
    // imem_req and instr_valid at once, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            retired_q     <= '0;
            misalign_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A stale ack that arrives here is ignored.
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        imem_req_q    <= 1'b0;
                        state_q       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (commit) begin
                        instr_valid_q <= 1'b0;
                        if (trap_hit) begin
                            // The PC keeps the faulting instruction's address.
                            // This instruction does not retire.
                            misalign_q <= 1'b1;
                            state_q    <= S_TRAP;
                        end else begin
                            pc_q       <= next_pc_d;
                            retired_q  <= retired_q + 32'd1;
                            imem_req_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_TRAP: begin
                    // Only a reset leaves this state.
                    state_q <= S_TRAP;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign retired     = retired_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: sequential flow, branch, jalr, spurious
// events, PC wrap, misaligned target and a reset in the middle of a fetch.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_a_src;
    logic        pc_b_src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        commit;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] retired;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_next_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_a_src   (pc_a_src),
        .pc_b_src   (pc_b_src),
        .imm        (imm),
        .rs1        (rs1),
        .commit     (commit),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .instr      (instr),
        .instr_valid(instr_valid),
        .retired    (retired),
        .misalign   (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait until a request is seen, insert wait states, then send a 1-cycle ack.
    task automatic fetch_ack(input logic [31:0] word, input int waits);
        int n = 0;
        while (!imem_req && n < 50) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            chk("fetch_req_timeout", {31'b0, imem_req}, 32'd1);
            return;
        end
        repeat (waits) tick();
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic do_commit(input logic a, input logic b,
                             input logic [31:0] imm_v, input logic [31:0] rs1_v);
        pc_a_src = a;
        pc_b_src = b;
        imm      = imm_v;
        rs1      = rs1_v;
        commit   = 1'b1;
        tick();
        commit   = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        pc_a_src   = 1'b0;
        pc_b_src   = 1'b0;
        imm        = 32'h0;
        rs1        = 32'h0;
        commit     = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        repeat (2) tick();

        // Reset state
        chk("rst_pc",       pc,                  32'h0);
        chk("rst_req",      {31'b0, imem_req},   32'd0);
        chk("rst_valid",    {31'b0, instr_valid}, 32'd0);
        chk("rst_retired",  retired,             32'd0);
        chk("rst_instr",    instr,               32'h0);
        chk("rst_misalign", {31'b0, misalign},   32'd0);

        // The first edge after release moves IDLE to FETCH.
        rst_n = 1'b1;
        tick();
        chk("first_req",  {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr,         32'h0);

        // Sequential flow: the PC steps 0, 4, 8, C.
        for (int i = 0; i < 3; i++) begin
            fetch_ack(32'h0000_0013 + (i << 7), 2);
            chk("seq_instr", instr, 32'h0000_0013 + (i << 7));
            chk("seq_valid", {31'b0, instr_valid}, 32'd1);
            chk("exec_req",  {31'b0, imem_req},    32'd0);
            if (i == 0) begin
                // A spurious ack in EXEC must not overwrite instr.
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
                tick();
                imem_ack   = 1'b0;
                chk("exec_ack_instr", instr, 32'h0000_0013);
                chk("exec_ack_req",   {31'b0, imem_req}, 32'd0);
            end
            // Without a commit, EXEC holds its state.
            tick();
            chk("exec_hold_pc",  pc, 32'(4 * i));
            chk("exec_hold_req", {31'b0, imem_req}, 32'd0);
            do_commit(1'b0, 1'b0, 32'h0, 32'h0);
            chk("seq_pc",    pc, 32'(4 * (i + 1)));
            chk("seq_valid_clr", {31'b0, instr_valid}, 32'd0);
        end
        chk("seq_retired", retired, 32'd3);

        // A commit during FETCH must be ignored.
        do_commit(1'b1, 1'b0, 32'h100, 32'h0);
        chk("fetch_commit_pc",  pc,      32'h0000_000C);
        chk("fetch_commit_ret", retired, 32'd3);

        // Move to 0x100, then take a branch backwards by 16.
        fetch_ack(32'h0000_0063, 1);
        do_commit(1'b1, 1'b0, 32'h0000_00F4, 32'h0);
        chk("pc_0x100", pc, 32'h0000_0100);
        fetch_ack(32'h0000_0063, 1);
        do_commit(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
        chk("branch_addr", imem_addr, 32'h0000_00F0);
        chk("branch_req",  {31'b0, imem_req}, 32'd1);

        // jalr: 0x2001 + 4 = 0x2005, and bit 0 is cleared to give 0x2004.
        fetch_ack(32'h0000_0067, 1);
        do_commit(1'b1, 1'b1, 32'h0000_0004, 32'h0000_2001);
        chk("jalr_pc", pc, 32'h0000_2004);

        // Jump to 0xFFFF_FFFC, then a sequential step wraps to 0.
        fetch_ack(32'h0000_0067, 1);
        do_commit(1'b1, 1'b1, 32'h0000_0004, 32'hFFFF_FFF8);
        chk("pre_wrap_pc", pc, 32'hFFFF_FFFC);
        fetch_ack(32'h0000_0013, 1);
        do_commit(1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_pc",      pc,      32'h0);
        chk("wrap_retired", retired, 32'd8);

        // Misaligned jalr target: 0x2002.
        fetch_ack(32'h0000_0067, 1);
        do_commit(1'b1, 1'b1, 32'h0, 32'h0000_2002);
`ifdef PC_MISALIGN_TRAP_EN
        chk("trap_pc",       pc,                   32'h0);
        chk("trap_misalign", {31'b0, misalign},    32'd1);
        chk("trap_retired",  retired,              32'd8);
        chk("trap_valid",    {31'b0, instr_valid}, 32'd0);
        repeat (3) tick();
        chk("trap_req",      {31'b0, imem_req},    32'd0);
`else
        chk("align_pc",       pc,                32'h0000_2000);
        chk("align_misalign", {31'b0, misalign}, 32'd0);
        chk("align_retired",  retired,           32'd9);
        chk("align_req",      {31'b0, imem_req}, 32'd1);
`endif

        // Reset again, then reset once more in the middle of a fetch wait.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rerun_req", {31'b0, imem_req}, 32'd1);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req",     {31'b0, imem_req}, 32'd0);
        chk("async_rst_pc",      pc,                32'h0);
        chk("async_rst_retired", retired,           32'd0);
        chk("async_rst_misalign", {31'b0, misalign}, 32'd0);

        // An ack that arrives while the unit is in IDLE is ignored.
        tick();
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0BAD_0BAD;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("idle_ack_instr", instr,                32'h0);
        chk("idle_ack_valid", {31'b0, instr_valid}, 32'd0);
        chk("post_rst_req",   {31'b0, imem_req},    32'd1);
        chk("post_rst_addr",  imem_addr,            32'h0);

        // A reset during EXEC drops instr_valid without waiting for an edge.
        fetch_ack(32'h0000_0033, 1);
        chk("post_rst_instr", instr, 32'h0000_0033);
        chk("post_rst_valid", {31'b0, instr_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("exec_rst_valid", {31'b0, instr_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Sequential PC stage that consumes the branch-condition stage's PC-source selects and produces the next fetch address.
- Holds the architectural PC and runs a request/acknowledge fetch handshake with instruction memory.
- Presents the fetched instruction to decode/execute and advances the PC only when execute signals commit.
- Sits between the branch-condition stage (upstream, feeds pc_a_src/pc_b_src) and instruction memory.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- pc_a_src  in  1  addend-A select from branch condition: 0 = constant 4, 1 = imm.
- pc_b_src  in  1  addend-B select from branch condition: 0 = pc, 1 = rs1 (jalr).
- imm  in  XLEN  sign-extended immediate of the current instruction.
- rs1  in  XLEN  rs1 register value of the current instruction.
- commit  in  1  execute has resolved the current instruction; sampled only in EXEC.
- imem_req  out  1  fetch request, held high until acknowledged.
- imem_addr  out  XLEN  fetch address, equals pc.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  in  XLEN  instruction word.
- pc  out  XLEN  current PC register.
- instr  out  XLEN  latched instruction word.
- instr_valid  out  1  instr is valid and awaiting commit.
- retired  out  32  count of committed instructions.
- misalign  out  1  misaligned-target trap flag (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired=0, misalign=0.
- States: IDLE, FETCH, EXEC, TRAP.
- IDLE -> FETCH: unconditionally on the first clock after reset release. imem_req=0 during IDLE.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, go to EXEC.
  - Fetch latency is at least 1 cycle after request; wait states are unbounded.
- EXEC:
  - imem_req=0; instr_valid=1.
  - On commit: pc<=next_pc, retired<=retired+1, instr_valid<=0, go to FETCH.
  - Without commit: hold all state.
- next_pc = (pc_a_src ? imm : 4) + (pc_b_src ? rs1 : pc), modulo 2^XLEN.
  - When pc_b_src=1, next_pc[0] is forced to 0 (jalr rule).
  - next_pc is combinational from current inputs; it is registered only at the commit edge.
- Boundary conditions:
  - imem_ack outside FETCH is ignored, including a stale ack arriving in IDLE after a mid-fetch reset.
  - commit outside EXEC is ignored.
  - The state machine makes ack and commit mutually exclusive, so no simultaneous-event priority is needed.
  - PC wraps from 32'hFFFF_FFFC + 4 to 0 with no flag.
  - retired wraps from 32'hFFFF_FFFF to 0.
  - Reset asserted during FETCH or EXEC drops imem_req and instr_valid immediately (asynchronous), not at the next edge.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - On commit, if next_pc[1:0] != 2'b00 (evaluated after the jalr bit-0 clear), the FSM enters TRAP instead of FETCH.
  - pc holds the faulting instruction's PC, misalign=1, retired is not incremented, imem_req=0, instr_valid=0.
  - TRAP exits only via reset.
- Undefined:
  - next_pc[1:0] is forced to 2'b00 before registering.
  - misalign is tied to 0; TRAP state is unreachable.

Test Plan:
- Sequential flow: reset with RESET_PC=0; ack each fetch after 2 wait cycles; commit with a_src=0, b_src=0 -> pc goes 0,4,8,C; retired=3 after 3 commits; imem_req low in every EXEC cycle.
- Taken branch: pc=0x100, a_src=1, b_src=0, imm=0xFFFF_FFF0 -> next fetch address 0x0F0.
- jalr: a_src=1, b_src=1, rs1=0x2001, imm=0x4 -> pc=0x2004 (bit 0 cleared); with PC_MISALIGN_TRAP_EN, rs1=0x2002, imm=0 -> TRAP, misalign=1, pc unchanged, no further imem_req.
- Spurious and wrap events:
  - commit pulsed in FETCH -> no pc change.
  - ack pulsed in EXEC -> instr unchanged.
  - pc=0xFFFF_FFFC, sequential commit -> pc=0.
- Reset mid-operation: assert rst_n low during FETCH wait -> imem_req=0 before the next edge; ack during IDLE ignored; first post-reset fetch address is RESET_PC.
